// File: rtl/mac_reg_pkg.sv
// Shared types and constants for the MAC register-access bridge.
package mac_reg_pkg;

  localparam int MAC_ADDR_W = 8;
  localparam int MAC_DATA_W = 32;

  // Read data returned when an access is aborted on timeout.
  localparam logic [MAC_DATA_W-1:0] ABORT_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    SEQ_ACC,
    HOST_ACC,
    HOST_DONE,
    GAP
  } state_e;

endpackage

// File: rtl/mac_reg_arbiter_if.sv
// Avalon-MM bus toward the MAC register space. The bridge drives it through
// the master modport; the MAC (or a bench model of it) uses the slave modport.
interface mac_reg_arbiter_if;
  import mac_reg_pkg::*;

  logic [MAC_ADDR_W-1:0] mac_address;
  logic [MAC_DATA_W-1:0] mac_writedata;
  logic                  mac_read;
  logic                  mac_write;
  logic [MAC_DATA_W-1:0] mac_readdata;
  logic                  mac_waitrequest;

  modport master (
    output mac_address, mac_writedata, mac_read, mac_write,
    input  mac_readdata, mac_waitrequest
  );

  modport slave (
    input  mac_address, mac_writedata, mac_read, mac_write,
    output mac_readdata, mac_waitrequest
  );

endinterface

// File: rtl/mac_reg_arbiter.sv
// Serialises sequencer and host register requests onto one Avalon-MM master,
// with a per-access waitrequest timeout. TIMEOUT must be at least 2.
module mac_reg_arbiter
  import mac_reg_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MAC_ADDR_W-1:0] seq_addr,
  input  logic [MAC_DATA_W-1:0] seq_writedata,
  input  logic                  seq_rd,
  input  logic                  seq_wr,
  input  logic                  seq_done,
  output logic [MAC_DATA_W-1:0] seq_readdata,
  output logic                  seq_busy,
  input  logic [MAC_ADDR_W-1:0] host_addr,
  input  logic [MAC_DATA_W-1:0] host_writedata,
  input  logic                  host_rd,
  input  logic                  host_wr,
  output logic [MAC_DATA_W-1:0] host_readdata,
  output logic                  host_waitrequest,
  mac_reg_arbiter_if.master     mac,
  output logic                  timeout_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MAC_ADDR_W-1:0] addr_q, addr_d;
  logic [MAC_DATA_W-1:0] wdata_q, wdata_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  busy_q, busy_d;
  logic [MAC_DATA_W-1:0] seq_rdata_q, seq_rdata_d;
  logic [MAC_DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic                  host_wait_q, host_wait_d;
  logic                  terr_q, terr_d;

  logic                  abort;
  logic                  finish;
  logic [MAC_DATA_W-1:0] rdata_sel;

  assign abort     = mac.mac_waitrequest && (cnt_q == CNT_LAST);
  assign finish    = !mac.mac_waitrequest || abort;
  assign rdata_sel = abort ? ABORT_RDATA : mac.mac_readdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    read_d       = read_q;
    write_d      = write_q;
    busy_d       = busy_q;
    seq_rdata_d  = seq_rdata_q;
    host_rdata_d = host_rdata_q;
    host_wait_d  = 1'b1;
    terr_d       = terr_q;

    case (state_q)
      IDLE: begin
        // seq_done selects the only source allowed to start an access.
        if (!seq_done && (seq_wr || seq_rd)) begin
          addr_d  = seq_addr;
          wdata_d = seq_writedata;
          write_d = seq_wr;
          read_d  = !seq_wr;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = SEQ_ACC;
        end else if (seq_done && (host_wr || host_rd)) begin
          addr_d  = host_addr;
          wdata_d = host_writedata;
          write_d = host_wr;
          read_d  = !host_wr;
          cnt_d   = '0;
          state_d = HOST_ACC;
        end
      end

      SEQ_ACC, HOST_ACC: begin
        if (finish) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (abort) terr_d = 1'b1;
          if (state_q == SEQ_ACC) begin
            if (read_q) seq_rdata_d = rdata_sel;
            busy_d  = 1'b0;
            state_d = GAP;
          end else begin
            if (read_q) host_rdata_d = rdata_sel;
            state_d = HOST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // host_waitrequest is registered, so the low pulse shows in the GAP cycle.
      HOST_DONE: begin
        host_wait_d = 1'b0;
        state_d     = GAP;
      end

      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      seq_rdata_q  <= '0;
      host_rdata_q <= '0;
      host_wait_q  <= 1'b1;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      busy_q       <= busy_d;
      seq_rdata_q  <= seq_rdata_d;
      host_rdata_q <= host_rdata_d;
      host_wait_q  <= host_wait_d;
      terr_q       <= terr_d;
    end
  end

  assign mac.mac_address   = addr_q;
  assign mac.mac_writedata = wdata_q;
  assign mac.mac_read      = read_q;
  assign mac.mac_write     = write_q;
  assign seq_readdata      = seq_rdata_q;
  assign seq_busy          = busy_q;
  assign host_readdata     = host_rdata_q;
  assign host_waitrequest  = host_wait_q;
  assign timeout_err       = terr_q;

endmodule

// File: tb/tb_mac_reg_arbiter.sv
// Cycle-by-cycle vector table for the arbiter, then hand sequences for the
// timeout abort and a reset taken in the middle of an access.
module tb_mac_reg_arbiter;

  logic        clk;
  logic        reset;
  logic [7:0]  seq_addr, host_addr;
  logic [31:0] seq_writedata, host_writedata;
  logic        seq_rd, seq_wr, seq_done, host_rd, host_wr;
  logic [31:0] seq_readdata, host_readdata;
  logic        seq_busy, host_waitrequest, timeout_err;

  int checks = 0;
  int errors = 0;

  mac_reg_arbiter_if mac_if ();

  mac_reg_arbiter #(.TIMEOUT(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .seq_addr         (seq_addr),
    .seq_writedata    (seq_writedata),
    .seq_rd           (seq_rd),
    .seq_wr           (seq_wr),
    .seq_done         (seq_done),
    .seq_readdata     (seq_readdata),
    .seq_busy         (seq_busy),
    .host_addr        (host_addr),
    .host_writedata   (host_writedata),
    .host_rd          (host_rd),
    .host_wr          (host_wr),
    .host_readdata    (host_readdata),
    .host_waitrequest (host_waitrequest),
    .mac              (mac_if),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in  = {reset, seq_done, seq_rd, seq_wr, host_rd, host_wr, mac_waitrequest}
  // out = {seq_busy, mac_read, mac_write, host_waitrequest, timeout_err}, after the edge
  // host_writedata is driven as ~wd so the two write-data sources differ.
  typedef struct {
    string       name;
    logic [6:0]  in;
    logic [7:0]  saddr;
    logic [7:0]  haddr;
    logic [31:0] wd;
    logic [31:0] mrdata;
    logic [4:0]  out;
    logic [7:0]  maddr;
    logic [31:0] mwd;
    logic [31:0] srdata;
    logic [31:0] hrdata;
  } vec_t;

  vec_t vt[$];
  vec_t v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t d);
    reset                  = d.in[6];
    seq_done               = d.in[5];
    seq_rd                 = d.in[4];
    seq_wr                 = d.in[3];
    host_rd                = d.in[2];
    host_wr                = d.in[1];
    mac_if.mac_waitrequest = d.in[0];
    seq_addr               = d.saddr;
    host_addr              = d.haddr;
    seq_writedata          = d.wd;
    host_writedata         = ~d.wd;
    mac_if.mac_readdata    = d.mrdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;

    v = '{"rst",         7'b1000000, 8'h00, 8'h00, 32'h0,        32'h0,        5'b00010, 8'h00, 32'h0,        32'h0,        32'h0};        vt.push_back(v);
    v = '{"sw_issue",    7'b0001001, 8'h03, 8'h00, 32'h06150910, 32'h0,        5'b10110, 8'h03, 32'h06150910, 32'h0,        32'h0};        vt.push_back(v);
    v = '{"sw_wait1",    7'b0001001, 8'h03, 8'h00, 32'h06150910, 32'h0,        5'b10110, 8'h03, 32'h06150910, 32'h0,        32'h0};        vt.push_back(v);
    v = '{"sw_wait2",    7'b0001001, 8'h03, 8'h00, 32'h06150910, 32'h0,        5'b10110, 8'h03, 32'h06150910, 32'h0,        32'h0};        vt.push_back(v);
    v = '{"sw_done",     7'b0001000, 8'h03, 8'h00, 32'h06150910, 32'h0,        5'b00010, 8'h03, 32'h06150910, 32'h0,        32'h0};        vt.push_back(v);
    v = '{"sw_gap",      7'b0001000, 8'h04, 8'h00, 32'hAAAA5555, 32'h0,        5'b00010, 8'h04, 32'hAAAA5555, 32'h0,        32'h0};        vt.push_back(v);
    v = '{"sw2_issue",   7'b0001000, 8'h04, 8'h00, 32'hAAAA5555, 32'h0,        5'b10110, 8'h04, 32'hAAAA5555, 32'h0,        32'h0};        vt.push_back(v);
    v = '{"sw2_done",    7'b0000000, 8'h04, 8'h00, 32'hAAAA5555, 32'h0,        5'b00010, 8'h04, 32'hAAAA5555, 32'h0,        32'h0};        vt.push_back(v);
    v = '{"sw2_gap",     7'b0000000, 8'h04, 8'h00, 32'h0,        32'h0,        5'b00010, 8'h04, 32'h0,        32'h0,        32'h0};        vt.push_back(v);
    v = '{"idle",        7'b0000000, 8'h00, 8'h00, 32'h0,        32'h0,        5'b00010, 8'h00, 32'h0,        32'h0,        32'h0};        vt.push_back(v);
    v = '{"sr_issue",    7'b0010001, 8'h02, 8'h00, 32'h0,        32'h0,        5'b11010, 8'h02, 32'h0,        32'h0,        32'h0};        vt.push_back(v);
    v = '{"sr_done",     7'b0010000, 8'h02, 8'h00, 32'h0,        32'h00002000, 5'b00010, 8'h02, 32'h0,        32'h00002000, 32'h0};        vt.push_back(v);
    v = '{"sr_gap",      7'b0010000, 8'h02, 8'h00, 32'h0,        32'h0,        5'b00010, 8'h02, 32'h0,        32'h00002000, 32'h0};        vt.push_back(v);
    v = '{"sr2_issue",   7'b0010001, 8'h02, 8'h00, 32'h0,        32'h0,        5'b11010, 8'h02, 32'h0,        32'h00002000, 32'h0};        vt.push_back(v);
    v = '{"sr2_wait",    7'b0010001, 8'h02, 8'h00, 32'h0,        32'hDEADBEEF, 5'b11010, 8'h02, 32'h0,        32'h00002000, 32'h0};        vt.push_back(v);
    v = '{"sr2_done",    7'b0010000, 8'h02, 8'h00, 32'h0,        32'h0,        5'b00010, 8'h02, 32'h0,        32'h0,        32'h0};        vt.push_back(v);
    v = '{"sr2_gap",     7'b0000000, 8'h02, 8'h00, 32'h0,        32'h0,        5'b00010, 8'h02, 32'h0,        32'h0,        32'h0};        vt.push_back(v);
    v = '{"h_blocked1",  7'b0000010, 8'h00, 8'h15, 32'h12345678, 32'h0,        5'b00010, 8'h00, 32'h0,        32'h0,        32'h0};        vt.push_back(v);
    v = '{"h_blocked2",  7'b0000010, 8'h00, 8'h15, 32'h12345678, 32'h0,        5'b00010, 8'h00, 32'h0,        32'h0,        32'h0};        vt.push_back(v);
    v = '{"h_issue",     7'b0100010, 8'h00, 8'h15, 32'h12345678, 32'h0,        5'b00110, 8'h15, 32'hEDCBA987, 32'h0,        32'h0};        vt.push_back(v);
    v = '{"h_wait",      7'b0100011, 8'h00, 8'h15, 32'h12345678, 32'h0,        5'b00110, 8'h15, 32'hEDCBA987, 32'h0,        32'h0};        vt.push_back(v);
    v = '{"h_done",      7'b0100010, 8'h00, 8'h15, 32'h12345678, 32'h0,        5'b00010, 8'h15, 32'hEDCBA987, 32'h0,        32'h0};        vt.push_back(v);
    v = '{"h_ack",       7'b0100010, 8'h00, 8'h15, 32'h12345678, 32'h0,        5'b00000, 8'h15, 32'hEDCBA987, 32'h0,        32'h0};        vt.push_back(v);
    v = '{"h_release",   7'b0100000, 8'h00, 8'h00, 32'h0,        32'h0,        5'b00010, 8'h00, 32'h0,        32'h0,        32'h0};        vt.push_back(v);
    v = '{"seq_ignored", 7'b0101000, 8'h33, 8'h00, 32'h0,        32'h0,        5'b00010, 8'h33, 32'h0,        32'h0,        32'h0};        vt.push_back(v);
    v = '{"hr_issue",    7'b0100100, 8'h00, 8'h20, 32'h0,        32'h0,        5'b01010, 8'h20, 32'h0,        32'h0,        32'h0};        vt.push_back(v);
    v = '{"hr_done",     7'b0100100, 8'h00, 8'h20, 32'h0,        32'hCAFEF00D, 5'b00010, 8'h20, 32'h0,        32'h0,        32'hCAFEF00D}; vt.push_back(v);
    v = '{"hr_ack",      7'b0100100, 8'h00, 8'h20, 32'h0,        32'h0,        5'b00000, 8'h20, 32'h0,        32'h0,        32'hCAFEF00D}; vt.push_back(v);
    v = '{"hr_release",  7'b0100000, 8'h00, 8'h00, 32'h0,        32'h0,        5'b00010, 8'h00, 32'h0,        32'h0,        32'hCAFEF00D}; vt.push_back(v);
    v = '{"both_issue",  7'b0011001, 8'h07, 8'h00, 32'h11112222, 32'h0,        5'b10110, 8'h07, 32'h11112222, 32'h0,        32'hCAFEF00D}; vt.push_back(v);
    v = '{"own_flip",    7'b0111001, 8'h07, 8'h00, 32'h11112222, 32'h0,        5'b10110, 8'h07, 32'h11112222, 32'h0,        32'hCAFEF00D}; vt.push_back(v);
    v = '{"own_done",    7'b0100000, 8'h07, 8'h00, 32'h11112222, 32'h0,        5'b00010, 8'h07, 32'h11112222, 32'h0,        32'hCAFEF00D}; vt.push_back(v);
    v = '{"own_gap",     7'b0100000, 8'h00, 8'h00, 32'h0,        32'h0,        5'b00010, 8'h00, 32'h0,        32'h0,        32'hCAFEF00D}; vt.push_back(v);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      tick();
      chk({vt[i].name, ".seq_busy"},  32'(seq_busy),          32'(vt[i].out[4]));
      chk({vt[i].name, ".mac_read"},  32'(mac_if.mac_read),   32'(vt[i].out[3]));
      chk({vt[i].name, ".mac_write"}, 32'(mac_if.mac_write),  32'(vt[i].out[2]));
      chk({vt[i].name, ".host_wait"}, 32'(host_waitrequest),  32'(vt[i].out[1]));
      chk({vt[i].name, ".tmo_err"},   32'(timeout_err),       32'(vt[i].out[0]));
      chk({vt[i].name, ".seq_rdata"}, seq_readdata,           vt[i].srdata);
      chk({vt[i].name, ".host_rdata"}, host_readdata,         vt[i].hrdata);
      if (vt[i].out[3] || vt[i].out[2])
        chk({vt[i].name, ".mac_addr"}, 32'(mac_if.mac_address), 32'(vt[i].maddr));
      if (vt[i].out[2])
        chk({vt[i].name, ".mac_wdata"}, mac_if.mac_writedata, vt[i].mwd);
      if (vt[i].in[6]) begin
        chk({vt[i].name, ".mac_addr"},  32'(mac_if.mac_address), 32'h0);
        chk({vt[i].name, ".mac_wdata"}, mac_if.mac_writedata,    32'h0);
      end
    end

    // Stuck waitrequest: the read must be aborted after exactly 16 command cycles.
    seq_done = 1'b0; seq_rd = 1'b1; seq_addr = 8'h09;
    mac_if.mac_waitrequest = 1'b1; mac_if.mac_readdata = 32'h1234_5678;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mac_if.mac_read) n++;
      else if (n > 0) break;
      chk("tmo.host_wait", 32'(host_waitrequest), 32'h1);
    end
    chk("tmo.cmd_cycles", n,                   32'd16);
    chk("tmo.seq_busy",   32'(seq_busy),       32'h0);
    chk("tmo.seq_rdata",  seq_readdata,        32'hFFFF_FFFF);
    chk("tmo.err",        32'(timeout_err),    32'h1);
    seq_rd = 1'b0; mac_if.mac_waitrequest = 1'b0;
    tick(); tick();
    seq_rd = 1'b1; seq_addr = 8'h0A; mac_if.mac_readdata = 32'h0000_0055;
    tick();
    chk("post_tmo.issue", 32'(mac_if.mac_read), 32'h1);
    tick();
    chk("post_tmo.rdata", seq_readdata,        32'h0000_0055);
    chk("post_tmo.err",   32'(timeout_err),    32'h1);
    seq_rd = 1'b0;
    tick(); tick();

    // Reset during SEQ_ACC with waitrequest held, then a clean restart.
    seq_wr = 1'b1; seq_addr = 8'h05; seq_writedata = 32'h0BAD_F00D;
    mac_if.mac_waitrequest = 1'b1;
    tick();
    chk("rmid.issue", 32'(mac_if.mac_write), 32'h1);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rmid.mac_write", 32'(mac_if.mac_write),   32'h0);
    chk("rmid.mac_read",  32'(mac_if.mac_read),    32'h0);
    chk("rmid.mac_addr",  32'(mac_if.mac_address), 32'h0);
    chk("rmid.mac_wdata", mac_if.mac_writedata,    32'h0);
    chk("rmid.seq_busy",  32'(seq_busy),           32'h0);
    chk("rmid.host_wait", 32'(host_waitrequest),   32'h1);
    chk("rmid.tmo_err",   32'(timeout_err),        32'h0);
    chk("rmid.seq_rdata", seq_readdata,            32'h0);
    chk("rmid.host_rdata", host_readdata,          32'h0);
    reset = 1'b0; mac_if.mac_waitrequest = 1'b0;
    tick();
    chk("restart.mac_write", 32'(mac_if.mac_write),   32'h1);
    chk("restart.seq_busy",  32'(seq_busy),           32'h1);
    chk("restart.mac_addr",  32'(mac_if.mac_address), 32'h05);
    chk("restart.mac_wdata", mac_if.mac_writedata,    32'h0BAD_F00D);
    tick();
    chk("restart.done_busy",  32'(seq_busy),          32'h0);
    chk("restart.done_write", 32'(mac_if.mac_write),  32'h0);
    seq_wr = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
